// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC register, req/ready instruction memory port,
// decode-facing output slot backed by a one-entry skid buffer, redirect and halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funcCode
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, addr_n, pc_plus4;
  logic        squash, squash_n;
  logic        halt_pend, halt_pend_n;
  logic        out_valid_n;
  logic [31:0] out_instr_n, out_pc_n;
  logic        skid_valid, skid_valid_n;
  logic [31:0] skid_instr, skid_instr_n, skid_pc, skid_pc_n;

  assign pc_plus4    = pc + 32'd4;
  assign imem_req    = (state == REQ);
  assign if_pc_plus4 = if_pc + 32'd4;
  assign opcode      = if_instr[31:26];
  assign funcCode    = if_instr[5:0];

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    addr_n       = imem_addr;
    squash_n     = squash;
    halt_pend_n  = halt_pend;
    out_valid_n  = if_valid & stall;
    out_instr_n  = if_instr;
    out_pc_n     = if_pc;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;

    case (state)
      IDLE: begin
        if (halt) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = HALT;
        end else if (redirect) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          pc_n         = redirect_pc;
          addr_n       = redirect_pc;
          state_n      = REQ;
        end else begin
          addr_n  = pc;
          state_n = REQ;
        end
      end

      // A halt seen mid-request is remembered so the request can finish its handshake.
      REQ: begin
        if (halt || halt_pend) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          if (imem_ready) begin
            halt_pend_n = 1'b0;
            squash_n    = 1'b0;
            state_n     = HALT;
          end else begin
            halt_pend_n = 1'b1;
          end
        end else if (redirect) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          pc_n         = redirect_pc;
          if (imem_ready) begin
            squash_n = 1'b0;
            addr_n   = redirect_pc;
          end else if (!squash) begin
            squash_n = 1'b1;
          end
        end else if (imem_ready) begin
          if (squash) begin
            squash_n = 1'b0;
            addr_n   = pc;
          end else begin
            pc_n   = pc_plus4;
            addr_n = pc_plus4;
            if (!if_valid || !stall) begin
              out_valid_n = 1'b1;
              out_instr_n = imem_rdata;
              out_pc_n    = imem_addr;
            end else begin
              skid_valid_n = 1'b1;
              skid_instr_n = imem_rdata;
              skid_pc_n    = imem_addr;
              state_n      = WAIT;
            end
          end
        end
      end

      WAIT: begin
        if (halt) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = HALT;
        end else if (redirect) begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
          pc_n         = redirect_pc;
          addr_n       = redirect_pc;
          state_n      = REQ;
        end else if (!stall) begin
          out_valid_n  = skid_valid;
          out_instr_n  = skid_instr;
          out_pc_n     = skid_pc;
          skid_valid_n = 1'b0;
          addr_n       = pc;
          state_n      = REQ;
        end
      end

      HALT: begin
        out_valid_n  = 1'b0;
        skid_valid_n = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      squash     <= 1'b0;
      halt_pend  <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      skid_valid <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      imem_addr  <= addr_n;
      squash     <= squash_n;
      halt_pend  <= halt_pend_n;
      if_valid   <= out_valid_n;
      if_instr   <= out_instr_n;
      if_pc      <= out_pc_n;
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS core: holds the program counter, fetches words from instruction memory over a req/ready handshake and presents one instruction at a time to decode. Its opcode/funcCode outputs feed the control decoder directly. It accepts stall from hazard logic, redirect (branch/jump/jr target) from decode, and halt (exit syscall). A one-entry skid buffer absorbs a response that returns while decode is stalled.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held high until imem_ready
- imem_addr  out  32  fetch address; stable while imem_req high
- imem_ready  in  1  response valid this cycle (may coincide with first req cycle)
- imem_rdata  in  32  instruction word, valid with imem_ready
- stall  in  1  decode cannot accept; output slot holds
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new fetch address, word aligned
- halt  in  1  stop fetching permanently (until reset)
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  32  instruction word
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4 (link value / branch base)
- opcode  out  6  if_instr[31:26]
- funcCode  out  6  if_instr[5:0]

## Operation
- Registers: pc (next address to request), imem_addr, squash flag, output slot (if_valid/if_instr/if_pc), skid slot (skid_valid/instr/pc), state.
- States: IDLE, REQ, WAIT, HALT. imem_req = 1 only in REQ.
- IDLE (one cycle after reset release): imem_addr <= pc, -> REQ.
- REQ, imem_ready=0: hold imem_addr; stay.
- REQ, imem_ready=1, squash=0: response goes to output slot if output empty or stall=0, else skid; pc <= pc+4; imem_addr <= pc+4. If skid will be full -> WAIT, else stay REQ (back-to-back, next request starts next cycle).
- REQ, imem_ready=1, squash=1: data dropped, squash <= 0, imem_addr <= pc, stay REQ.
- WAIT: req low; when stall=0 skid moves to output slot, -> REQ with imem_addr <= pc.
- Output slot: stall=0 and no new data -> if_valid <= 0 (consumed); stall=1 -> hold all output fields.
- redirect (any state except HALT): if_valid <= 0, skid_valid <= 0, pc <= redirect_pc. REQ without ready: squash <= 1, imem_addr unchanged. REQ with ready same cycle: data dropped, no squash, imem_addr <= redirect_pc. IDLE/WAIT: imem_addr <= redirect_pc, -> REQ.
- Priority: halt > redirect > stall. Redirect during squash=1 only updates pc.
- halt: outstanding request (if any) completes and is dropped; if_valid, skid_valid <= 0; -> HALT; no further requests. Only rst_n exits HALT.
- Arithmetic 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset (async, immediate): state IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_req 0, squash 0, if_valid 0, if_instr 0, if_pc 0, if_pc_plus4 4, opcode 0, funcCode 0, skid empty.
- First imem_req on second rising edge after rst_n deassertion.
- Latency: imem_ready in cycle N -> if_valid=1 after edge N (visible cycle N+1).
- Zero-wait memory, no stall: one instruction per cycle.
- Redirect in cycle N: if_valid=0 in N+1; first new fetch request at redirect_pc in N+1 (no pending request) or after pending response drains.
- rst_n low mid-request: abandon request; imem_req drops asynchronously.

## Test plan
- Reset release, zero-wait memory returning addr-as-data -> if_pc 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; opcode/funcCode match if_instr fields.
- Memory with 3-cycle ready delay -> imem_addr stable while req high; one if_valid pulse per 4 cycles.
- stall high 3 cycles with response in flight -> output holds, response lands in skid, imem_req low; on release, skid instruction appears next cycle, no loss or duplicate.
- redirect to 0x00400100 while request at 0x00400008 pending -> late response dropped, next if_pc = 0x00400100.
- redirect and imem_ready same cycle -> that word dropped; next request addr 0x00400100 next cycle.
- halt during pending request, then redirect -> request completes, if_valid stays 0, imem_req never reasserts until rst_n pulse.
